// File: rtl/rr_arb_lzc.sv
// Round-robin stream arbiter: find-first-set from a rotating pointer, built from
// two trailing-zero counters over the masked and raw request vectors.

module lzc #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 3,
  parameter bit MODE      = 1'b0   // 0: trailing zeros, 1: leading zeros
) (
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  always_comb begin
    cnt_o = '0;
    if (!MODE) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in_i[i]) cnt_o = CNT_WIDTH'(WIDTH - 1 - i);
      end
    end
  end

  assign empty_o = ~|in_i;

endmodule

// state       | meaning
// ST_UNLOCKED | winner chosen fresh each cycle from the rotating pointer
// ST_LOCKED   | stalled transfer pending; winner pinned to lock_idx_q
module rr_arb_lzc #(
  parameter int NUM_REQ    = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_IN    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [NUM_REQ-1:0]    req_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  input  logic [DATA_WIDTH-1:0] data_i [NUM_REQ],
  output logic                  req_o,
  input  logic                  gnt_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] idx_o
);

  localparam int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e          lock_q, lock_d;
  logic [IDX_WIDTH-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_WIDTH-1:0] rr_q, rr_d;

  logic [NUM_REQ-1:0]   mask;
  logic [NUM_REQ-1:0]   req_masked;
  logic [IDX_WIDTH-1:0] masked_idx, raw_idx, arb_idx, winner;
  logic                 masked_empty, raw_empty;
  logic                 handshake;
  logic [DATA_WIDTH-1:0] data_sel;

  // Only requesters strictly after the last-served index keep priority.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (IDX_WIDTH'(i) > rr_q);
    end
  end

  assign req_masked = req_i & mask;

  lzc #(.WIDTH(NUM_REQ), .CNT_WIDTH(IDX_WIDTH), .MODE(1'b0)) u_lzc_masked (
    .in_i    (req_masked),
    .cnt_o   (masked_idx),
    .empty_o (masked_empty)
  );

  lzc #(.WIDTH(NUM_REQ), .CNT_WIDTH(IDX_WIDTH), .MODE(1'b0)) u_lzc_raw (
    .in_i    (req_i),
    .cnt_o   (raw_idx),
    .empty_o (raw_empty)
  );

  assign arb_idx   = masked_empty ? raw_idx : masked_idx;
  assign winner    = (lock_q == ST_LOCKED) ? lock_idx_q : arb_idx;
  assign req_o     = ~raw_empty;
  assign idx_o     = req_o ? winner : '0;
  assign handshake = req_o & gnt_i;

  always_comb begin
    gnt_o    = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx_o == IDX_WIDTH'(i)) begin
        gnt_o[i] = handshake;
        data_sel = data_i[i];
      end
    end
  end

  assign data_o = req_o ? data_sel : '0;

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    if (flush_i) begin
      lock_d = ST_UNLOCKED;
      rr_d   = IDX_WIDTH'(NUM_REQ - 1);
    end else begin
      if (handshake) rr_d = idx_o;
      case (lock_q)
        ST_UNLOCKED: begin
          if ((LOCK_IN != 0) && req_o && !gnt_i) begin
            lock_d     = ST_LOCKED;
            lock_idx_d = idx_o;
          end
        end
        ST_LOCKED: begin
          if (handshake) lock_d = ST_UNLOCKED;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_q     <= ST_UNLOCKED;
      lock_idx_q <= '0;
      rr_q       <= IDX_WIDTH'(NUM_REQ - 1);
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
    end
  end

`ifndef SYNTHESIS
  // A locked requester must keep its request up and its payload unchanged.
  logic [DATA_WIDTH-1:0] prev_data_q;

  always_ff @(posedge clk_i) begin
    prev_data_q <= data_o;
    if (rst_ni && (lock_q == ST_LOCKED)) begin
      assert (req_i[lock_idx_q])
        else $error("rr_arb_lzc: locked requester %0d dropped req_i", lock_idx_q);
      assert (data_o == prev_data_q)
        else $error("rr_arb_lzc: locked requester %0d changed data_i", lock_idx_q);
    end
  end
`endif

endmodule
